reg_file_dump_reader: RTL and testbench

Sequential read-side client for the reg_file read port. On a start pulse it walks an inclusive, wrapping address range. It drives rs_addr into the register file, captures each rs_val, and presents {addr, data} beats on a valid/ready output stream. The block sits between the core register file and the debug/trace path, and lets the bench or debug logic dump architectural state without stalling writeback.

---
 rtl/reg_file_dump_reader_if.sv | 28 ++
 rtl/reg_file_dump_reader.sv | 99 +++++++++
 tb/tb_reg_file_dump_reader.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/reg_file_dump_reader_if.sv
// Bundle between the dump reader, the register-file read port and the
// downstream valid/ready beat stream.
interface reg_file_dump_reader_if #(
  parameter int addr_width_p = 6,
  parameter int W1           = 32
);
  logic                    start_i;
  logic [addr_width_p-1:0] first_addr_i;
  logic [addr_width_p-1:0] last_addr_i;
  logic [addr_width_p-1:0] rs_addr_o;
  logic [W1-1:0]           rs_val_i;
  logic                    valid_o;
  logic                    ready_i;
  logic [addr_width_p-1:0] addr_o;
  logic [W1-1:0]           data_o;
  logic                    busy_o;
  logic                    done_o;

  modport master (
    input  start_i, first_addr_i, last_addr_i, rs_val_i, ready_i,
    output rs_addr_o, valid_o, addr_o, data_o, busy_o, done_o
  );

  modport slave (
    output start_i, first_addr_i, last_addr_i, rs_val_i, ready_i,
    input  rs_addr_o, valid_o, addr_o, data_o, busy_o, done_o
  );
endinterface

// File: rtl/reg_file_dump_reader.sv
// Walks an inclusive, wrapping register range through the reg_file rs port
// and emits {addr, data} beats on a valid/ready stream.
module reg_file_dump_reader #(
  parameter int addr_width_p = 6,
  parameter int W1           = 32
) (
  input  logic                   clk,
  input  logic                   reset_i,
  reg_file_dump_reader_if.master bus
);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_HOLD, S_DONE} state_t;

  state_t                  r_state;
  logic [addr_width_p-1:0] r_cur;
  logic [addr_width_p-1:0] r_last;
  logic [addr_width_p-1:0] r_addr;
  logic [W1-1:0]           r_data;
  logic                    r_valid;

  state_t w_state_nxt;
  logic   w_latch;
  logic   w_capture;
  logic   w_adv;
  logic   w_valid_nxt;

  always_ff @(posedge clk) begin
    if (reset_i) begin
      r_state <= S_IDLE;
      r_cur   <= '0;
      r_last  <= '0;
      r_addr  <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_valid <= w_valid_nxt;
      if (w_latch) begin
        r_cur  <= bus.first_addr_i;
        r_last <= bus.last_addr_i;
      end else if (w_adv) begin
        // natural modulo 2**addr_width_p wrap through the top register
        r_cur <= r_cur + addr_width_p'(1);
      end
      if (w_capture) begin
        r_addr <= r_cur;
        r_data <= bus.rs_val_i;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_latch     = 1'b0;
    w_capture   = 1'b0;
    w_adv       = 1'b0;
    w_valid_nxt = r_valid;
    case (r_state)
      S_IDLE: begin
        if (bus.start_i) begin
          w_latch     = 1'b1;
          w_state_nxt = S_READ;
        end
      end
      S_READ: begin
        // capture sees the pre-write value if the reg_file is written this edge
        w_capture   = 1'b1;
        w_valid_nxt = 1'b1;
        w_state_nxt = S_HOLD;
      end
      S_HOLD: begin
        if (r_valid && bus.ready_i) begin
          w_valid_nxt = 1'b0;
          if (r_cur == r_last) begin
            w_state_nxt = S_DONE;
          end else begin
            w_adv       = 1'b1;
            w_state_nxt = S_READ;
          end
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_valid_nxt = 1'b0;
      end
    endcase
  end

  assign bus.rs_addr_o = r_cur;
  assign bus.valid_o   = r_valid;
  assign bus.addr_o    = r_addr;
  assign bus.data_o    = r_data;
  assign bus.busy_o    = (r_state != S_IDLE);
  assign bus.done_o    = (r_state == S_DONE);

endmodule

// File: tb/tb_reg_file_dump_reader.sv
// Directed bench for reg_file_dump_reader with a behavioural 64x32 reg_file.
module tb_reg_file_dump_reader;
  localparam int AW = 6;
  localparam int DW = 32;

  logic clk;
  logic reset_i;
  int   n_tests;
  int   n_fail;

  reg_file_dump_reader_if #(.addr_width_p(AW), .W1(DW)) bus ();

  reg_file_dump_reader #(.addr_width_p(AW), .W1(DW)) dut (
    .clk     (clk),
    .reset_i (reset_i),
    .bus     (bus)
  );

  // reg_file model: combinational read, write on the rising edge
  logic [DW-1:0] rf      [64];
  logic [DW-1:0] rf_init [64];
  logic          load;
  logic          wen;
  logic [AW-1:0] waddr;
  logic [DW-1:0] wdata;

  always @(posedge clk) begin
    if (load) rf <= rf_init;
    else if (wen) rf[waddr] <= wdata;
  end

  assign bus.rs_val_i = rf[bus.rs_addr_o];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic load_rf(input int mode);
    for (int i = 0; i < 64; i++)
      rf_init[i] = (mode == 0) ? DW'(i * 3) : DW'(32'hA000 + i);
    load = 1'b1;
    step();
    load = 1'b0;
  endtask

  // Full dump with ready held high: beats exactly every 2 cycles, then done pulse.
  task automatic dump(input logic [AW-1:0] f, input logic [AW-1:0] l, input int nb, input string tag);
    logic [AW-1:0] a;
    a = f;
    bus.first_addr_i = f;
    bus.last_addr_i  = l;
    bus.ready_i      = 1'b1;
    bus.start_i      = 1'b1;
    step();
    bus.start_i = 1'b0;
    chk({tag, ".busy_start"}, 32'(bus.busy_o), 32'(1));
    chk({tag, ".valid_read"}, 32'(bus.valid_o), 32'(0));
    for (int k = 0; k < nb; k++) begin
      step();
      chk({tag, ".valid"}, 32'(bus.valid_o), 32'(1));
      chk({tag, ".addr"},  32'(bus.addr_o),  32'(a));
      chk({tag, ".data"},  bus.data_o,       rf[a]);
      chk({tag, ".done_early"}, 32'(bus.done_o), 32'(0));
      step();
      if (k < nb - 1) chk({tag, ".gap"}, 32'(bus.valid_o), 32'(0));
      a = a + AW'(1);
    end
    chk({tag, ".done"},       32'(bus.done_o),  32'(1));
    chk({tag, ".valid_done"}, 32'(bus.valid_o), 32'(0));
    chk({tag, ".busy_done"},  32'(bus.busy_o),  32'(1));
    step();
    chk({tag, ".done_clr"}, 32'(bus.done_o), 32'(0));
    chk({tag, ".busy_clr"}, 32'(bus.busy_o), 32'(0));
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    load = 1'b0; wen = 1'b0; waddr = '0; wdata = '0;
    bus.start_i = 1'b0; bus.first_addr_i = '0; bus.last_addr_i = '0; bus.ready_i = 1'b0;
    reset_i = 1'b1;
    step();
    step();
    reset_i = 1'b0;
    chk("rst.valid",   32'(bus.valid_o),   32'(0));
    chk("rst.busy",    32'(bus.busy_o),    32'(0));
    chk("rst.done",    32'(bus.done_o),    32'(0));
    chk("rst.addr",    32'(bus.addr_o),    32'(0));
    chk("rst.data",    bus.data_o,         32'(0));
    chk("rst.rs_addr", 32'(bus.rs_addr_o), 32'(0));

    // 1: basic 4-beat dump
    load_rf(0);
    dump(6'd0, 6'd3, 4, "t1");

    // 2: back-pressure on beat 2
    bus.first_addr_i = 6'd0; bus.last_addr_i = 6'd3; bus.ready_i = 1'b1; bus.start_i = 1'b1;
    step();
    bus.start_i = 1'b0;
    step(); chk("t2.b0", 32'(bus.addr_o), 32'(0));
    step();
    step(); chk("t2.b1", bus.data_o, 32'd3);
    step();
    step(); chk("t2.b2", bus.data_o, 32'd6);
    bus.ready_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t2.stall_valid", 32'(bus.valid_o), 32'(1));
      chk("t2.stall_addr",  32'(bus.addr_o),  32'(2));
      chk("t2.stall_data",  bus.data_o,       32'd6);
    end
    bus.ready_i = 1'b1;
    step(); chk("t2.gap", 32'(bus.valid_o), 32'(0));
    step();
    chk("t2.b3_valid", 32'(bus.valid_o), 32'(1));
    chk("t2.b3_addr",  32'(bus.addr_o),  32'(3));
    chk("t2.b3_data",  bus.data_o,       32'd9);
    step(); chk("t2.done", 32'(bus.done_o), 32'(1));
    step(); chk("t2.idle", 32'(bus.busy_o), 32'(0));

    // 3/4: wrap and extremes
    load_rf(1);
    dump(6'd62, 6'd1, 4, "t3");
    dump(6'd5, 6'd5, 1, "t4a");
    dump(6'd0, 6'd63, 64, "t4b");

    // 5: start ignored while busy, then reset mid-dump
    load_rf(0);
    bus.first_addr_i = 6'd20; bus.last_addr_i = 6'd23; bus.ready_i = 1'b1; bus.start_i = 1'b1;
    step();
    bus.start_i = 1'b0;
    step(); chk("t5.b20", 32'(bus.addr_o), 32'd20);
    bus.ready_i = 1'b0;
    bus.start_i = 1'b1; bus.first_addr_i = 6'd40; bus.last_addr_i = 6'd41;
    step();
    bus.start_i = 1'b0;
    chk("t5.hold_addr", 32'(bus.addr_o), 32'd20);
    chk("t5.hold_data", bus.data_o,      32'd60);
    bus.ready_i = 1'b1;
    step(); chk("t5.gap", 32'(bus.valid_o), 32'(0));
    step();
    chk("t5.b21_addr", 32'(bus.addr_o), 32'd21);
    chk("t5.b21_data", bus.data_o,      32'd63);
    step();
    step(); chk("t5.b22_addr", 32'(bus.addr_o), 32'd22);
    reset_i = 1'b1;
    step();
    reset_i = 1'b0;
    chk("t5.rst_valid", 32'(bus.valid_o), 32'(0));
    chk("t5.rst_busy",  32'(bus.busy_o),  32'(0));
    chk("t5.rst_done",  32'(bus.done_o),  32'(0));
    step();
    chk("t5.rst_done2", 32'(bus.done_o), 32'(0));
    chk("t5.rst_busy2", 32'(bus.busy_o), 32'(0));
    dump(6'd10, 6'd11, 2, "t5b");

    // 6: write to the register being captured returns the old value
    wen = 1'b1; waddr = 6'd7; wdata = 32'h1234;
    step();
    wen = 1'b0;
    bus.first_addr_i = 6'd7; bus.last_addr_i = 6'd7; bus.ready_i = 1'b1; bus.start_i = 1'b1;
    step();
    bus.start_i = 1'b0;
    wen = 1'b1; waddr = 6'd7; wdata = 32'hDEAD;
    step();
    wen = 1'b0;
    chk("t6.addr", 32'(bus.addr_o), 32'd7);
    chk("t6.old",  bus.data_o,      32'h1234);
    step(); chk("t6.done", 32'(bus.done_o), 32'(1));
    step();
    dump(6'd7, 6'd7, 1, "t6b");
    chk("t6.new", bus.data_o, 32'hDEAD);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
